// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and width defaults for the VRAM arbiter slice
package vram_arb_pkg;
    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 8;
    typedef enum logic {PRIO_DISP, PRIO_CPU} arb_state_t;
    typedef enum logic {OWN_DISP, OWN_CPU} owner_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display/CPU requester handshakes plus the VRAM port, as seen by the arbiter
interface vram_arbiter_if import vram_arb_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] vram_address;
    logic              vram_w_enable;
    logic [DATA_W-1:0] vram_w_data;
    logic [DATA_W-1:0] vram_r_data;

    modport master (
        output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_r_data,
        input  disp_gnt, disp_rvalid, disp_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
        input  vram_address, vram_w_enable, vram_w_data
    );

    modport slave (
        input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_r_data,
        output disp_gnt, disp_rvalid, disp_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
        output vram_address, vram_w_enable, vram_w_data
    );
endinterface

// File: rtl/vram_arb_starve_cnt.sv
// vram_arb_starve_cnt: counts consecutive denied CPU cycles and raises force_cpu at the threshold
module vram_arb_starve_cnt #(
    parameter int CPU_MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic cpu_gnt,
    output logic force_cpu
);
    logic [7:0] wait_cnt;
    logic       denied;

    assign denied    = cpu_req & ~cpu_gnt;
    assign force_cpu = denied & (wait_cnt >= 8'(CPU_MAX_WAIT - 1));

    // consecutive-denial count; any grant or dropped request restarts it, saturates at all-ones
    always_ff @(posedge clk)
        wait_cnt <= (rst || !denied) ? 8'd0 : (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: display-priority VRAM arbiter with CPU starvation guard (optional stats: VRAM_ARB_STATS_EN)
module vram_arbiter import vram_arb_pkg::*; #(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int VRAM_DEPTH   = 1 << ADDR_W,
    parameter int CPU_MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
`ifdef VRAM_ARB_STATS_EN
    output logic [31:0] stat_conflicts,
    output logic [15:0] stat_forced,
`endif
    vram_arbiter_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(VRAM_DEPTH);

    arb_state_t        state, state_nxt;
    owner_t            rd_owner;
    logic              force_cpu, disp_gnt, cpu_gnt, disp_in, cpu_in;
    logic              rd_valid, rd_zero, disp_hit, cpu_hit;
    logic [DATA_W-1:0] rdata, disp_q, cpu_q;

    assign disp_in = {1'b0, bus.disp_addr} < DEPTH_L;
    assign cpu_in  = {1'b0, bus.cpu_addr} < DEPTH_L;

    vram_arb_starve_cnt #(.CPU_MAX_WAIT(CPU_MAX_WAIT)) u_starve (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (bus.cpu_req),
        .cpu_gnt   (cpu_gnt),
        .force_cpu (force_cpu)
    );

    // priority state register
    always_ff @(posedge clk)
        state <= rst ? PRIO_DISP : state_nxt;

    // a forced CPU slot lasts one cycle, whether or not the CPU still wants it
    always_comb
        state_nxt = (state == PRIO_DISP && force_cpu) ? PRIO_CPU : PRIO_DISP;

    // grants: the prioritised side wins, the other only takes an idle cycle
    always_comb begin
        cpu_gnt  = ~rst & bus.cpu_req & ((state == PRIO_CPU) | ~bus.disp_req);
        disp_gnt = ~rst & bus.disp_req & ~cpu_gnt;
    end

    assign bus.disp_gnt = disp_gnt;
    assign bus.cpu_gnt  = cpu_gnt;

    // VRAM port follows whichever side holds the grant; out-of-range writes are dropped
    always_comb begin
        bus.vram_address  = cpu_gnt ? bus.cpu_addr : disp_gnt ? bus.disp_addr : '0;
        bus.vram_w_enable = cpu_gnt & bus.cpu_we & cpu_in;
        bus.vram_w_data   = cpu_gnt ? bus.cpu_wdata : '0;
    end

    // remember who issued the read in flight and whether it must return zero
    always_ff @(posedge clk) begin
        rd_valid <= ~rst & (disp_gnt | (cpu_gnt & ~bus.cpu_we));
        rd_owner <= (~rst & cpu_gnt) ? OWN_CPU : OWN_DISP;
        rd_zero  <= ~rst & (cpu_gnt ? ~cpu_in : ~disp_in);
    end

    assign disp_hit = ~rst & rd_valid & (rd_owner == OWN_DISP);
    assign cpu_hit  = ~rst & rd_valid & (rd_owner == OWN_CPU);
    assign rdata    = rd_zero ? '0 : bus.vram_r_data;

    assign bus.disp_rvalid = disp_hit;
    assign bus.cpu_rvalid  = cpu_hit;
    assign bus.disp_rdata  = rst ? '0 : disp_hit ? rdata : disp_q;
    assign bus.cpu_rdata   = rst ? '0 : cpu_hit ? rdata : cpu_q;

    // hold each requester's last returned data between its reads
    always_ff @(posedge clk) begin
        disp_q <= rst ? '0 : bus.disp_rdata;
        cpu_q  <= rst ? '0 : bus.cpu_rdata;
    end

`ifdef VRAM_ARB_STATS_EN
    // saturating contention and forced-slot counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_conflicts <= '0;
            stat_forced    <= '0;
        end else begin
            if (bus.disp_req && bus.cpu_req && stat_conflicts != '1)
                stat_conflicts <= stat_conflicts + 32'd1;
            if (state == PRIO_DISP && state_nxt == PRIO_CPU && stat_forced != '1)
                stat_forced <= stat_forced + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed plus random stimulus, reference model and read-return scoreboard
module tb_vram_arbiter;
    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 1024;
    localparam int MAXW  = 4;

    typedef struct {
        int            cyc;
        logic          own_cpu;
        logic [DW-1:0] data;
    } rd_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic load = 1'b1;
    int   cyc  = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   streak = 0;
    logic d_taken = 1'b0;
    logic c_taken = 1'b0;
    logic [DW-1:0] last_d = '0;
    logic [DW-1:0] last_c = '0;
    logic [DW-1:0] vmem [0:2047];
    logic [DW-1:0] ref_mem [int];
    rd_t q[$];

`ifdef VRAM_ARB_STATS_EN
    logic [31:0] stat_conflicts;
    logic [15:0] stat_forced;
`endif

    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .VRAM_DEPTH(DEPTH), .CPU_MAX_WAIT(MAXW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef VRAM_ARB_STATS_EN
        .stat_conflicts (stat_conflicts),
        .stat_forced    (stat_forced),
`endif
        .bus            (bus)
    );

    function automatic logic [DW-1:0] seed_val(int a);
        return (a == 'h10) ? 8'hA5 : (8'(a) ^ 8'h5A);
    endfunction

    function automatic logic [DW-1:0] mem_read(int a);
        if (a >= DEPTH) return '0;
        return ref_mem.exists(a) ? ref_mem[a] : seed_val(a);
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // VRAM: registered read, one-cycle latency
    always @(posedge clk) begin
        if (load) for (int i = 0; i < 2048; i++) vmem[i] <= seed_val(i);
        else if (bus.vram_w_enable) vmem[bus.vram_address] <= bus.vram_w_data;
        bus.vram_r_data <= vmem[bus.vram_address];
    end

    // reference model: display wins unless the CPU has already been refused MAXW times in a row
    always @(negedge clk) begin
        logic e_cpu, e_disp, e_we;
        logic [AW-1:0] e_addr;
        if (rst) begin
            streak = 0;
            chk("rst_disp_gnt", bus.disp_gnt, 0);
            chk("rst_cpu_gnt", bus.cpu_gnt, 0);
            chk("rst_vram_address", bus.vram_address, 0);
            chk("rst_vram_w_enable", bus.vram_w_enable, 0);
            chk("rst_vram_w_data", bus.vram_w_data, 0);
        end else begin
            e_cpu  = bus.cpu_req && (!bus.disp_req || streak >= MAXW);
            e_disp = bus.disp_req && !e_cpu;
            e_addr = e_cpu ? bus.cpu_addr : e_disp ? bus.disp_addr : '0;
            e_we   = e_cpu && bus.cpu_we && (int'(bus.cpu_addr) < DEPTH);
            chk("disp_gnt", bus.disp_gnt, e_disp);
            chk("cpu_gnt", bus.cpu_gnt, e_cpu);
            chk("vram_address", bus.vram_address, e_addr);
            chk("vram_w_enable", bus.vram_w_enable, e_we);
            chk("vram_w_data", bus.vram_w_data, e_cpu ? bus.cpu_wdata : 0);
            if (e_cpu && bus.cpu_we) begin
                if (e_we) ref_mem[int'(bus.cpu_addr)] = bus.cpu_wdata;
            end else if (e_cpu || e_disp) begin
                q.push_back(rd_t'{cyc, e_cpu, mem_read(int'(e_addr))});
            end
            streak = (bus.cpu_req && !e_cpu) ? streak + 1 : 0;
        end
        d_taken = bus.disp_gnt;
        c_taken = bus.cpu_gnt;
    end

    // monitor: a read granted last cycle must return now, to its owner only
    always @(negedge clk) begin
        logic ev_d, ev_c;
        rd_t it;
        ev_d = 1'b0;
        ev_c = 1'b0;
        if (rst) begin
            q.delete();
            last_d = '0;
            last_c = '0;
        end else if (q.size() > 0 && q[0].cyc == cyc - 1) begin
            it = q.pop_front();
            if (it.own_cpu) begin
                ev_c = 1'b1;
                last_c = it.data;
            end else begin
                ev_d = 1'b1;
                last_d = it.data;
            end
        end
        chk("disp_rvalid", bus.disp_rvalid, ev_d);
        chk("cpu_rvalid", bus.cpu_rvalid, ev_c);
        chk("disp_rdata", bus.disp_rdata, last_d);
        chk("cpu_rdata", bus.cpu_rdata, last_c);
    end

    initial begin
        bus.disp_req  = 1'b1;
        bus.disp_addr = 'h20;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 'h30;
        bus.cpu_wdata = '0;
        repeat (3) step();
        rst  = 1'b0;
        load = 1'b0;
        repeat (15) step();
        bus.disp_req = 1'b0;
        bus.cpu_req  = 1'b0;
        step();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 'h10;
        step();
        bus.disp_req = 1'b0;
        step();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 'h100;
        bus.cpu_wdata = 8'h3C;
        step();
        bus.cpu_req = 1'b0;
        step();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 'h100;
        step();
        bus.disp_req = 1'b0;
        step();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 'h400;
        bus.cpu_wdata = 8'h77;
        step();
        bus.cpu_we = 1'b0;
        step();
        bus.cpu_req = 1'b0;
        step();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 'h55;
        step();
        bus.cpu_req = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        repeat (3000) begin
            if (!bus.disp_req || d_taken) begin
                bus.disp_req  = $urandom_range(0, 99) < 70;
                bus.disp_addr = AW'($urandom_range(0, 1100));
            end
            if (!bus.cpu_req || c_taken) begin
                bus.cpu_req   = $urandom_range(0, 99) < 50;
                bus.cpu_we    = $urandom_range(0, 99) < 40;
                bus.cpu_addr  = AW'($urandom_range(0, 1100));
                bus.cpu_wdata = DW'($urandom);
            end
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        bus.disp_req = 1'b0;
        bus.cpu_req  = 1'b0;
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port VRAM between two requesters: the display scanout path (read-only) and a CPU/host port (read/write).
- Sits between the VGA/GPU controller path and the vram instance, and owns vram_address, w_enable and w_data.
- Display gets fixed priority. A starvation counter forces a CPU slot after a bounded wait.
- The display requester must tolerate an occasional stalled cycle.

Parameters:
- ADDR_W, 20, VRAM address width.
- DATA_W, 8, VRAM data width.
- VRAM_DEPTH, 1 << ADDR_W, number of valid locations; addresses >= VRAM_DEPTH are out of range.
- CPU_MAX_WAIT, 16, consecutive cycles a CPU request may be denied before a CPU grant is forced; legal range 1..255.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- disp_req  in  1  display read request.
- disp_addr  in  ADDR_W  display read address.
- disp_gnt  out  1  display request accepted this cycle.
- disp_rvalid  out  1  disp_rdata valid (one cycle after disp_gnt).
- disp_rdata  out  DATA_W  display read data.
- cpu_req  in  1  CPU request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after a read grant).
- cpu_rdata  out  DATA_W  CPU read data.
- vram_address  out  ADDR_W  to VRAM.
- vram_w_enable  out  1  to VRAM write enable.
- vram_w_data  out  DATA_W  to VRAM write data.
- vram_r_data  in  DATA_W  from VRAM; registered read, 1-cycle latency.

Behaviour:
Reset and clocking:
- One clock.
- Reset is synchronous, active-high.

Reset values:
- All grants, rvalids, rdata, vram_* outputs: 0.
- State: PRIO_DISP.
- wait_cnt: 0.
- Pending read pipeline: cleared; an in-flight read is dropped and no rvalid appears after reset.

FSM (2 states):
- PRIO_DISP:
  - disp_req wins.
  - cpu_req is granted only when disp_req=0.
- PRIO_CPU:
  - cpu_req wins, even over disp_req.
  - After exactly one CPU grant, next state is PRIO_DISP.
  - If cpu_req drops while in PRIO_CPU, return to PRIO_DISP next cycle without granting.

Starvation counter:
- wait_cnt increments each cycle with cpu_req=1 and cpu_gnt=0, saturating.
- Reset to 0 on any cpu_gnt or when cpu_req=0.
- When wait_cnt reaches CPU_MAX_WAIT-1 while still denied, next state is PRIO_CPU.

Grants:
- Combinational from state and requests; at most one grant per cycle.
- A requester must hold req/addr/data stable until its gnt is seen.

VRAM drive:
- vram_address/w_enable/w_data are a combinational mux of the granted requester.
- No grant: address 0, w_enable 0, w_data 0.
- w_enable=1 only for a granted CPU write with in-range address.

Read return:
- 1-bit owner register plus valid register track the granted read.
- Next cycle, the matching *_rvalid=1 and *_rdata=vram_r_data.
- Non-owner rdata holds its last value.
- Writes produce no rvalid.

Out-of-range addresses:
- Write: granted but suppressed (w_enable=0).
- Read: granted; rvalid asserted with rdata=0.

Back-to-back behaviour:
- Grants are allowed every cycle.
- A display grant in cycle N and a CPU grant in N+1 return data in N+1 and N+2 respectively.

Optional Feature:
VRAM_ARB_STATS_EN
- Defined: adds outputs stat_conflicts (32 bit) and stat_forced (16 bit).
  - stat_conflicts counts cycles with disp_req & cpu_req both 1.
  - stat_forced counts entries into PRIO_CPU.
  - Both saturate and clear on rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package vram_arb_pkg holds:
  - enum arb_state_t {PRIO_DISP, PRIO_CPU};
  - enum owner_t {OWN_DISP, OWN_CPU};
  - localparam defaults for ADDR_W and DATA_W.
- One natural sub-module: vram_arb_starve_cnt (saturating wait counter with threshold compare, outputs force_cpu).

Test Plan:
1. Reset with both reqs high for 3 cycles:
   - All outputs 0 during reset.
   - First cycle after release: disp_gnt=1, cpu_gnt=0.
2. Display-only read of addr 0x00010, VRAM holding 0xA5:
   - disp_gnt cycle N.
   - disp_rvalid=1 and disp_rdata=0xA5 at N+1.
3. Both requesting continuously with CPU_MAX_WAIT=4:
   - CPU denied for 4 cycles.
   - cpu_gnt=1 on the 5th cycle, with disp_gnt=0 that cycle.
   - The pattern repeats every 5 cycles.
4. CPU write 0x3C to 0x00100 while disp idle:
   - vram_w_enable=1, vram_address=0x00100, w_data=0x3C in the grant cycle.
   - No cpu_rvalid.
   - Subsequent display read of 0x00100 returns 0x3C.
5. Out-of-range CPU write then read at VRAM_DEPTH (depth 1024, addr 0x00400):
   - Write: w_enable stays 0.
   - Read: cpu_rvalid=1 with rdata=0.
6. rst asserted in the cycle after a CPU read grant:
   - cpu_rvalid stays 0.
   - wait_cnt and state return to 0/PRIO_DISP.
